// File: rtl/reset_ctrl_pkg.sv
// rtl/reset_ctrl_pkg.sv - shared state encoding and tick defaults for the reset button controller
package reset_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_POR   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_PRESS = 3'd2,
        ST_LOAD  = 3'd3,
        ST_LONG  = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    localparam int DEF_TICK_DIV   = 50000;
    localparam int DEF_POR_TICKS  = 100;
    localparam int DEF_LONG_TICKS = 1000;
    localparam int DEF_LOAD_TICKS = 2;
    localparam int DEF_HOLD_TICKS = 20;

    function automatic int max_ticks(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/reset_tick_gen.sv
// rtl/reset_tick_gen.sv - free-running prescaler producing a one-cycle timing tick
module reset_tick_gen #(
    parameter int TICK_DIV = reset_ctrl_pkg::DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    always_comb begin
        presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
        tick    = (presc_q == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/reset_button_ctrl.sv
// rtl/reset_button_ctrl.sv - classifies button presses into LOAD pulses or held system resets
module reset_button_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int POR_TICKS  = DEF_POR_TICKS,
    parameter int LONG_TICKS = DEF_LONG_TICKS,
    parameter int LOAD_TICKS = DEF_LOAD_TICKS,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic reset_button,
    output logic sys_reset,
    output logic load,
    output logic busy
);

    localparam int CNT_W = $clog2(max_ticks(POR_TICKS, LONG_TICKS, LOAD_TICKS, HOLD_TICKS)) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] POR_T   = CNT_W'(POR_TICKS);
    localparam logic [CNT_W-1:0] LONG_T  = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] LOAD_T  = CNT_W'(LOAD_TICKS);
    localparam logic [CNT_W-1:0] HOLD_T  = CNT_W'(HOLD_TICKS);

    logic             tick;
    logic [1:0]       sync_q, sync_d;
    logic             btn_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sys_reset_q, sys_reset_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;

    reset_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

    assign btn_s = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], reset_button};
        state_d = state_q;
        case (state_q)
            ST_POR:   if (cnt_q >= POR_T) state_d = btn_s ? ST_LONG : ST_IDLE;
            ST_IDLE:  if (btn_s) state_d = ST_PRESS;
            // The long threshold is tested first so a simultaneous release still yields a full reset.
            ST_PRESS: begin
                if (cnt_q >= LONG_T)  state_d = ST_LONG;
                else if (!btn_s)      state_d = ST_LOAD;
            end
            ST_LOAD:  if (cnt_q >= LOAD_T) state_d = ST_IDLE;
            ST_LONG:  if (!btn_s) state_d = ST_HOLD;
            ST_HOLD: begin
                if (btn_s)                state_d = ST_LONG;
                else if (cnt_q >= HOLD_T) state_d = ST_IDLE;
            end
            default:  state_d = ST_POR;
        endcase

        if (state_d != state_q)
            cnt_d = '0;
        else if (tick && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = cnt_q;

        // Outputs are decoded from the next state so they switch on the same edge as the state.
        sys_reset_d = (state_d == ST_POR) || (state_d == ST_LONG) || (state_d == ST_HOLD);
        load_d      = (state_d == ST_LOAD);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '0;
            state_q     <= ST_POR;
            cnt_q       <= '0;
            sys_reset_q <= 1'b1;
            load_q      <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sys_reset_q <= sys_reset_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
        end
    end

    assign sys_reset = sys_reset_q;
    assign load      = load_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reset_button_ctrl.sv
// tb/tb_reset_button_ctrl.sv - directed self-checking bench for reset_button_ctrl
module tb_reset_button_ctrl;

    logic clk;
    logic reset_n;
    logic reset_button;
    logic sys_reset;
    logic load;
    logic busy;

    int checks = 0;
    int errors = 0;
    int sr_seen = 0;
    int ld_seen = 0;
    int both_seen = 0;

    reset_button_ctrl #(
        .TICK_DIV  (4),
        .POR_TICKS (5),
        .LONG_TICKS(10),
        .LOAD_TICKS(2),
        .HOLD_TICKS(3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .reset_button(reset_button),
        .sys_reset   (sys_reset),
        .load        (load),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sys_reset === 1'b1) sr_seen++;
        if (load === 1'b1) ld_seen++;
        if (sys_reset === 1'b1 && load === 1'b1) both_seen++;
    end

    // Returns the number of falling edges until the selected output equals val (limit+1 on timeout).
    task automatic wait_sig(input int sel, input logic val, input int limit, output int n);
        logic v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            v = (sel == 0) ? sys_reset : ((sel == 1) ? load : busy);
        end while (v !== val && n <= limit);
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        reset_button = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sys_reset !== 1'b1) begin errors++; $display("FAIL reset_sys_reset got %b want 1", sys_reset); end
        checks++;
        if (load !== 1'b0) begin errors++; $display("FAIL reset_load got %b want 0", load); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
        reset_n = 1'b1;
        wait_sig(0, 1'b0, 100, n);
        checks++;
        if (n - 1 < 16 || n - 1 > 24) begin errors++; $display("FAIL por_duration got %0d cycles want 16..24", n - 1); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL por_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_short_press();
        int n, w, s0;
        s0 = sr_seen;
        reset_button = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL short_busy got %b want 1", busy); end
        reset_button = 1'b0;
        wait_sig(1, 1'b1, 10, n);
        checks++;
        if (n < 2 || n > 5) begin errors++; $display("FAIL short_load_delay got %0d want 2..5", n); end
        wait_sig(1, 1'b0, 20, w);
        checks++;
        if (w < 4 || w > 12) begin errors++; $display("FAIL short_load_width got %0d want 4..12", w); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL short_idle_busy got %b want 0", busy); end
        repeat (4) @(negedge clk);
        checks++;
        if (sr_seen != s0) begin errors++; $display("FAIL short_sys_reset got %0d high cycles want 0", sr_seen - s0); end
    endtask

    task automatic test_long_press();
        int n, m, s0, l0;
        l0 = ld_seen;
        reset_button = 1'b1;
        wait_sig(0, 1'b1, 60, n);
        checks++;
        if (n < 36 || n > 48) begin errors++; $display("FAIL long_rise got %0d want 36..48", n); end
        s0 = sr_seen;
        repeat (60 - n) @(negedge clk);
        checks++;
        if (sr_seen - s0 != 60 - n) begin errors++; $display("FAIL long_held got %0d want %0d", sr_seen - s0, 60 - n); end
        reset_button = 1'b0;
        wait_sig(0, 1'b0, 30, m);
        checks++;
        if (m - 1 < 8 || m - 1 > 16) begin errors++; $display("FAIL long_fall got %0d want 8..16", m - 1); end
        checks++;
        if (ld_seen != l0) begin errors++; $display("FAIL long_no_load got %0d load cycles want 0", ld_seen - l0); end
    endtask

    task automatic test_hold_repress();
        int n, m, s0;
        reset_button = 1'b1;
        wait_sig(0, 1'b1, 60, n);
        checks++;
        if (n > 60) begin errors++; $display("FAIL hold_first_rise got timeout want rise"); end
        repeat (6) @(negedge clk);
        reset_button = 1'b0;
        s0 = sr_seen;
        repeat (5) @(negedge clk);
        reset_button = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (sr_seen - s0 != 15) begin errors++; $display("FAIL hold_continuous got %0d want 15", sr_seen - s0); end
        reset_button = 1'b0;
        wait_sig(0, 1'b0, 30, m);
        checks++;
        if (m - 1 < 8 || m - 1 > 16) begin errors++; $display("FAIL hold_restart_fall got %0d want 8..16", m - 1); end
    endtask

    task automatic test_por_held();
        int m, s0, l0;
        reset_n = 1'b0;
        reset_button = 1'b1;
        repeat (3) @(negedge clk);
        l0 = ld_seen;
        s0 = sr_seen;
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (sr_seen - s0 != 40) begin errors++; $display("FAIL por_held_sys_reset got %0d want 40", sr_seen - s0); end
        reset_button = 1'b0;
        wait_sig(0, 1'b0, 30, m);
        checks++;
        if (m - 1 < 8 || m - 1 > 16) begin errors++; $display("FAIL por_held_fall got %0d want 8..16", m - 1); end
        checks++;
        if (ld_seen != l0) begin errors++; $display("FAIL por_held_no_load got %0d want 0", ld_seen - l0); end
    endtask

    task automatic test_reset_in_load();
        int n;
        reset_button = 1'b1;
        repeat (12) @(negedge clk);
        reset_button = 1'b0;
        wait_sig(1, 1'b1, 10, n);
        checks++;
        if (n > 10) begin errors++; $display("FAIL rl_load_seen got timeout want load"); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (load !== 1'b0) begin errors++; $display("FAIL rl_async_load got %b want 0", load); end
        checks++;
        if (sys_reset !== 1'b1) begin errors++; $display("FAIL rl_async_sys_reset got %b want 1", sys_reset); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rl_async_busy got %b want 1", busy); end
        @(negedge clk);
        reset_n = 1'b1;
        wait_sig(0, 1'b0, 60, n);
        checks++;
        if (n - 1 < 16 || n - 1 > 24) begin errors++; $display("FAIL rl_por_duration got %0d want 16..24", n - 1); end
    endtask

    initial begin
        reset_n = 1'b0;
        reset_button = 1'b0;
        test_reset();
        test_short_press();
        test_long_press();
        test_hold_repress();
        test_por_held();
        test_reset_in_load();
        checks++;
        if (both_seen != 0) begin errors++; $display("FAIL load_sys_reset_overlap got %0d cycles want 0", both_seen); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_button_ctrl.md
RESET_BUTTON_CTRL -- requirements
Module: reset_button_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000: clk cycles per timing tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter POR_TICKS, default 100: minimum power-on sys_reset duration, in ticks.
REQ-003 SHALL have parameter LONG_TICKS, default 1000: press duration at or above which a press is long (full reset).
REQ-004 SHALL have parameter LOAD_TICKS, default 2: duration of the load pulse for a short press.
REQ-005 SHALL have parameter HOLD_TICKS, default 20: sys_reset stretch after a long press is released.
REQ-006 SHALL have port clk, input, 1: sole clock; all logic is in this clock domain.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port reset_button, input, 1: debounced button level (1 = pressed) from the upstream button deserializer; treated as asynchronous.
REQ-009 SHALL have port sys_reset, output, 1: active-high system reset to the console core.
REQ-010 SHALL have port load, output, 1: active-high LOAD interrupt request (short press).
REQ-011 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL synchronize reset_button through two flops to btn_s; FSM sees btn_s only (2-cycle input latency).
REQ-013 SHALL run a free-running prescaler 0..TICK_DIV-1 that emits a one-cycle tick when it equals TICK_DIV-1, then wraps to 0.
REQ-014 SHALL keep a tick counter, cleared on every state transition, incremented on tick, saturating at its maximum (width = clog2 of the largest tick parameter + 1).
REQ-015 SHALL implement states POR, IDLE, PRESS, LOAD, LONG, HOLD.
REQ-016 POR: sys_reset=1; -> IDLE when count >= POR_TICKS and btn_s=0; with count reached and btn_s=1 -> LONG.
REQ-017 IDLE: sys_reset=0, load=0; btn_s=1 -> PRESS.
REQ-018 PRESS: outputs as IDLE; btn_s=0 with count < LONG_TICKS -> LOAD; count reaching LONG_TICKS -> LONG; when both occur in the same cycle, LONG wins.
REQ-019 LOAD: load=1; -> IDLE after LOAD_TICKS ticks; btn_s is ignored in LOAD, and a level still high on return to IDLE starts a new PRESS.
REQ-020 LONG: sys_reset=1 while btn_s=1; btn_s=0 -> HOLD.
REQ-021 HOLD: sys_reset=1; -> IDLE after HOLD_TICKS ticks; btn_s=1 during HOLD -> LONG, and the hold restarts on the next release.
REQ-022 SHALL register sys_reset, load and busy, decoded from the next state so they change on the same edge as the state register.
REQ-023 SHALL never assert load and sys_reset in the same cycle.
REQ-024 Timing granularity SHALL be ±1 tick, because the prescaler is not realigned on state entry.

Reset
REQ-025 reset_n low SHALL asynchronously force state=POR, sys_reset=1, load=0, busy=1, and clear the synchronizer, prescaler and tick counter.
REQ-026 reset_n assertion mid-operation (any state) SHALL abort it; the block restarts from POR after release.
REQ-027 reset_n release SHALL be synchronous to clk, to be provided by the system; the block performs no internal release synchronization.

Structure
REQ-028 SHALL place the FSM state encoding in a shared package (reset_ctrl_pkg), with defaults for the tick parameters.
REQ-029 SHALL instantiate one sub-module, reset_tick_gen, containing the prescaler, with parameter TICK_DIV and output tick.

Verification (TICK_DIV=4, POR_TICKS=5, LONG_TICKS=10, LOAD_TICKS=2, HOLD_TICKS=3)
REQ-030 Release reset_n, button idle -> sys_reset=1 for 20 +/- 4 cycles, then 0 and busy=0.
REQ-031 Press for 12 cycles -> load=1 for 8 +/- 4 cycles starting 2-5 cycles after release; sys_reset stays 0.
REQ-032 Press for 60 cycles -> sys_reset rises about 40 cycles after press, stays high while pressed, and falls 12 +/- 4 cycles after release.
REQ-033 Re-press during HOLD -> sys_reset stays continuously high; HOLD restarts after the second release.
REQ-034 Button held through POR -> sys_reset stays high until release plus HOLD; load never asserts.
REQ-035 reset_n pulsed low during LOAD -> load drops asynchronously, sys_reset=1 immediately, and the POR sequence repeats.
